// File: rtl/arbitro_funcionalidades.sv
// Timed functionality arbiter: per-user IDLE/WAIT/GRANT/DONE FSMs with permission mask and per-function priority.
// Optional preemption by a strictly higher waiting level when ARBITRO_PREEMPT_EN is defined.
module arbitro_funcionalidades #(
  parameter int N_USERS     = 2,
  parameter int FUNC_W      = 3,
  parameter int PRIO_W      = 3,
  parameter int HOLD_CYCLES = 16
) (
  input  logic                                   i_clk,
  input  logic                                   i_reset,
  input  logic [N_USERS-1:0]                     i_req_valid,
  input  logic [N_USERS*PRIO_W-1:0]              i_req_level,
  input  logic [N_USERS*FUNC_W-1:0]              i_req_func,
  input  logic [(2**PRIO_W)*(2**FUNC_W)-1:0]     i_perm_mask,
  output logic [N_USERS-1:0]                     o_grant,
  output logic [N_USERS-1:0]                     o_denied,
  output logic [N_USERS-1:0]                     o_preempted,
  output logic [(2**FUNC_W)-1:0]                 o_func_active
);
  localparam int NF    = 2**FUNC_W;
  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_GRANT, S_DONE} state_t;

  state_t              r_state [N_USERS];
  logic [CNT_W-1:0]    r_cnt   [N_USERS];
  logic [FUNC_W-1:0]   r_func  [N_USERS];
  logic [PRIO_W-1:0]   r_lvl   [N_USERS];
  logic [N_USERS-1:0]  r_grant, r_denied, r_preempted;
  logic [NF-1:0]       r_func_active;

  state_t              w_st_n  [N_USERS];
  logic [CNT_W-1:0]    w_cnt_n [N_USERS];
  logic [FUNC_W-1:0]   w_fn_n  [N_USERS];
  logic [PRIO_W-1:0]   w_lv_n  [N_USERS];
  logic [N_USERS-1:0]  w_gnt_n, w_den_n, w_pre_n;
  logic [NF-1:0]       w_fa_n;

  logic [FUNC_W-1:0]   w_func  [N_USERS];
  logic [PRIO_W-1:0]   w_lvl   [N_USERS];
  logic [N_USERS-1:0]  w_perm, w_elig, w_win, w_chal;

  // Mask index {level, func} equals level*NF + func.
  for (genvar gi = 0; gi < N_USERS; gi++) begin : g_dec
    assign w_func[gi] = i_req_func[gi*FUNC_W +: FUNC_W];
    assign w_lvl[gi]  = i_req_level[gi*PRIO_W +: PRIO_W];
    assign w_perm[gi] = (w_func[gi] != '0) && i_perm_mask[{w_lvl[gi], w_func[gi]}];
    assign w_elig[gi] = (r_state[gi] == S_WAIT) && i_req_valid[gi] && w_perm[gi] &&
                        !r_func_active[w_func[gi]];
  end

  always_comb begin
    w_win  = w_elig;
    w_chal = '0;
    for (int i = 0; i < N_USERS; i++) begin
      for (int j = 0; j < N_USERS; j++) begin
        if (j != i && w_elig[j] && w_func[j] == w_func[i] &&
            (w_lvl[j] > w_lvl[i] || (w_lvl[j] == w_lvl[i] && j < i)))
          w_win[i] = 1'b0;
`ifdef ARBITRO_PREEMPT_EN
        if (j != i && r_state[i] == S_GRANT && r_state[j] == S_WAIT && i_req_valid[j] &&
            w_perm[j] && w_func[j] == r_func[i] && w_lvl[j] > r_lvl[i])
          w_chal[i] = 1'b1;
`endif
      end
    end
  end

  always_comb begin
    w_gnt_n = '0;
    w_den_n = '0;
    w_pre_n = '0;
    w_fa_n  = '0;
    for (int i = 0; i < N_USERS; i++) begin
      w_st_n[i]  = r_state[i];
      w_cnt_n[i] = r_cnt[i];
      w_fn_n[i]  = r_func[i];
      w_lv_n[i]  = r_lvl[i];
      case (r_state[i])
        S_IDLE:
          if (i_req_valid[i]) begin
            if (w_perm[i]) w_st_n[i] = S_WAIT;
            else begin
              w_st_n[i]  = S_DONE;
              w_den_n[i] = 1'b1;
            end
          end
        S_WAIT:
          if (!i_req_valid[i]) w_st_n[i] = S_IDLE;
          else if (!w_perm[i]) begin
            w_st_n[i]  = S_DONE;
            w_den_n[i] = 1'b1;
          end else if (w_win[i]) begin
            w_st_n[i]  = S_GRANT;
            w_cnt_n[i] = CNT_W'(HOLD_CYCLES - 1);
            w_fn_n[i]  = w_func[i];
            w_lv_n[i]  = w_lvl[i];
            w_gnt_n[i] = 1'b1;
          end
        S_GRANT:
          // Release wins over preemption and expiry: the user gave it up voluntarily.
          if (!i_req_valid[i] || w_func[i] != r_func[i]) begin
            w_st_n[i]  = S_IDLE;
            w_cnt_n[i] = '0;
          end else if (w_chal[i]) begin
            w_st_n[i]  = S_DONE;
            w_cnt_n[i] = '0;
            w_pre_n[i] = 1'b1;
          end else if (r_cnt[i] == '0) begin
            w_st_n[i]  = S_DONE;
          end else begin
            w_cnt_n[i] = r_cnt[i] - 1'b1;
            w_gnt_n[i] = 1'b1;
          end
        S_DONE:
          if (!i_req_valid[i]) w_st_n[i] = S_IDLE;
        default: w_st_n[i] = S_IDLE;
      endcase
      if (w_gnt_n[i]) w_fa_n[w_fn_n[i]] = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < N_USERS; i++) begin
        r_state[i] <= S_IDLE;
        r_cnt[i]   <= '0;
        r_func[i]  <= '0;
        r_lvl[i]   <= '0;
      end
      r_grant       <= '0;
      r_denied      <= '0;
      r_preempted   <= '0;
      r_func_active <= '0;
    end else begin
      for (int i = 0; i < N_USERS; i++) begin
        r_state[i] <= w_st_n[i];
        r_cnt[i]   <= w_cnt_n[i];
        r_func[i]  <= w_fn_n[i];
        r_lvl[i]   <= w_lv_n[i];
      end
      r_grant       <= w_gnt_n;
      r_denied      <= w_den_n;
      r_preempted   <= w_pre_n;
      r_func_active <= w_fa_n;
    end
  end

  assign o_grant       = r_grant;
  assign o_denied      = r_denied;
  assign o_preempted   = r_preempted;
  assign o_func_active = r_func_active;
endmodule
